div_arbiter: RTL and testbench
==============================

Name: div_arbiter

Overview:
- Shares one iterative divider instance among NREQ requesters using round-robin arbitration.
- Per requester: valid/ready request channel (operands) and valid/ready response channel (quotient, remainder, error).
- Sequences the divider through its load/run/done protocol. The divider loads operands while its active-low load input is low and raises done when finished.
- Sits between client blocks and the divider core in the arithmetic datapath.

Parameters:
- N, 4, operand/result width; must match the divider's N.
- NREQ, 2, number of requesters; 2..8.
- TIMEOUT_CYC, 2**N+4, watchdog limit in RUN cycles; used only with DIV_ARB_TIMEOUT_EN.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  one-hot (or zero) accept.
- req_dividend  in  NREQ*N  flattened; slice i = requester i.
- req_divisor  in  NREQ*N  flattened.
- resp_valid  out  NREQ  one-hot response valid.
- resp_ready  in  NREQ  per-requester response ready.
- resp_quotient  out  N  shared response data.
- resp_remainder  out  N  shared response data.
- resp_error  out  1  divide-by-zero or timeout.
- div_load_n  out  1  to divider rst; low = load operands.
- div_dividend  out  N  registered operand to divider.
- div_divisor  out  N  registered operand to divider.
- div_quotient  in  N  from divider.
- div_remainder  in  N  from divider.
- div_done  in  1  from divider.
- div_error  in  1  from divider.

Behaviour:
- Reset (rst=1 at edge):
  - state=IDLE; RR pointer=NREQ-1, so requester 0 has highest priority first.
  - req_ready=0, resp_valid=0, resp_quotient/remainder/error=0, div_dividend/div_divisor=0.
  - div_load_n is driven 0 while rst=1, so the divider is held loaded. It is 1 otherwise, except in LOAD.
- State machine: IDLE -> LOAD -> RUN -> RESP -> IDLE. All outputs are registered except req_ready.
- IDLE:
  - Grant = first asserted req_valid searching from pointer+1, wrapping.
  - req_ready[grant]=1 combinationally; all other bits 0.
  - On the accept edge (valid&ready): latch slice grant into div_dividend/div_divisor, store grant index, pointer<=grant, go to LOAD.
  - No valid: stay in IDLE, pointer unchanged.
- LOAD: exactly 1 cycle with div_load_n=0; div_done is ignored. Next state is RUN.
- RUN:
  - div_load_n=1; operands held stable.
  - On a cycle with div_done=1: latch div_quotient, div_remainder, div_error into the resp registers and go to RESP.
- RESP:
  - resp_valid[grant]=1; data held stable.
  - When resp_ready[grant]=1 at an edge: resp_valid<=0 and state<=IDLE. The next grant is possible in the following cycle.
  - resp_ready bits of other requesters are ignored.
- Latency:
  - Let the accept edge be edge 0. resp_valid rises after edge q+3, where q is the quotient.
  - Divisor=0: resp_valid rises after edge 3, with quotient=0, remainder=0, error=1.
- Throughput: at most one division in flight; req_ready=0 outside IDLE.
- Fairness: a requester granted once is lowest priority in the next arbitration. Two simultaneous requests therefore alternate.
- Requesters must hold req_valid and operands until accepted. Dropping req_valid before accept is legal; no grant results.
- Reset mid-operation (any state): the operation is abandoned and no response is issued. Reset values above apply.

Optional Feature:
- Macro: DIV_ARB_TIMEOUT_EN.
- Defined:
  - A RUN-cycle counter clears on entering RUN.
  - If it reaches TIMEOUT_CYC without div_done: go to RESP with quotient=0, remainder=0, error=1.
- Undefined: no counter; RUN waits indefinitely for div_done.

Decomposition:
- Package div_arb_pkg:
  - state enum {IDLE, LOAD, RUN, RESP}.
  - IDX_W = $clog2(NREQ) localparam function.
  - Default N/NREQ constants.
- Sub-module rr_arbiter: combinational round-robin grant.
  - Inputs: req vector, pointer.
  - Outputs: one-hot grant, index, any.
- div_arbiter instantiates rr_arbiter. The divider core is external, connected by the div_* ports.

Test Plan (N=4, NREQ=2, bench connects the real divider):
- Req0 13/3 alone, resp_ready=1 -> resp_valid[0] rises after edge 7; quotient=4, remainder=1, error=0; req_ready[1] never asserted.
- Req0 7/9 and req1 15/5 asserted in the same cycle after reset -> req0 served first (q=0, r=7, valid after edge 3); req1 served next (q=3, r=0).
- Both requesters continuously valid for 6 transactions -> grants alternate 0,1,0,1,0,1.
- Req1 9/0 -> resp_valid[1] after edge 3; quotient=0, remainder=0, error=1.
- resp_ready[0] held low 5 cycles during 14/2 -> resp_valid[0] stays high with q=7, r=0 stable; no new req_ready until 1 cycle after the response handshake.
- rst pulsed during RUN of 15/1 -> no response; all outputs at reset values; a following req0 6/2 returns q=3, r=0. With DIV_ARB_TIMEOUT_EN and TIMEOUT_CYC=3, 15/1 returns error=1, quotient=0, remainder=0.

Source files
------------

// File: rtl/div_arb_pkg.sv
// Shared types and constants for the round-robin divider arbiter.
package div_arb_pkg;

  localparam int DEF_N    = 4;
  localparam int DEF_NREQ = 2;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN,
    RESP
  } state_t;

  // Index width for a requester vector; never below 1 so ports stay legal.
  function automatic int idx_w(input int nreq);
    return (nreq > 1) ? $clog2(nreq) : 1;
  endfunction

endpackage

// File: rtl/div_arbiter_rr_arbiter.sv
// Combinational round-robin grant: searches from ptr+1, wrapping, for the first request.
module rr_arbiter #(
  parameter int NREQ  = 2,
  parameter int IDX_W = 1
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic [NREQ-1:0]  grant,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  int cand;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    cand  = 0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = (int'(ptr) + k) % NREQ;
      if (!any && req[cand]) begin
        any         = 1'b1;
        grant[cand] = 1'b1;
        idx         = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/div_arbiter.sv
// Shares one external iterative divider among NREQ requesters (round robin).
// Optional RUN watchdog enabled by defining DIV_ARB_TIMEOUT_EN.
module div_arbiter
  import div_arb_pkg::*;
#(
  parameter int N           = DEF_N,
  parameter int NREQ        = DEF_NREQ,
  parameter int TIMEOUT_CYC = 2**N + 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*N-1:0] req_dividend,
  input  logic [NREQ*N-1:0] req_divisor,
  output logic [NREQ-1:0]   resp_valid,
  input  logic [NREQ-1:0]   resp_ready,
  output logic [N-1:0]      resp_quotient,
  output logic [N-1:0]      resp_remainder,
  output logic              resp_error,
  output logic              div_load_n,
  output logic [N-1:0]      div_dividend,
  output logic [N-1:0]      div_divisor,
  input  logic [N-1:0]      div_quotient,
  input  logic [N-1:0]      div_remainder,
  input  logic              div_done,
  input  logic              div_error
);

  localparam int IDX_W = idx_w(NREQ);

  if (NREQ < 2 || NREQ > 8 || TIMEOUT_CYC < 1) begin : g_param_check
    $error("div_arbiter: NREQ must be 2..8 and TIMEOUT_CYC at least 1");
  end

  state_t           state;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] grant_idx;
  logic             load_n_q;
  logic [NREQ-1:0]  arb_grant;
  logic [IDX_W-1:0] arb_idx;
  logic             arb_any;

  rr_arbiter #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_rr (
    .req   (req_valid),
    .ptr   (ptr),
    .grant (arb_grant),
    .idx   (arb_idx),
    .any   (arb_any)
  );

  // Only the arbitration grant is combinational; reset keeps the divider loaded.
  assign req_ready  = (state == IDLE && !rst) ? arb_grant : '0;
  assign div_load_n = rst ? 1'b0 : load_n_q;

`ifdef DIV_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] run_cnt;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      ptr            <= IDX_W'(NREQ - 1);
      grant_idx      <= '0;
      load_n_q       <= 1'b1;
      resp_valid     <= '0;
      resp_quotient  <= '0;
      resp_remainder <= '0;
      resp_error     <= 1'b0;
      div_dividend   <= '0;
      div_divisor    <= '0;
`ifdef DIV_ARB_TIMEOUT_EN
      run_cnt        <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (arb_any) begin
            div_dividend <= req_dividend[int'(arb_idx)*N +: N];
            div_divisor  <= req_divisor[int'(arb_idx)*N +: N];
            grant_idx    <= arb_idx;
            ptr          <= arb_idx;
            load_n_q     <= 1'b0;
            state        <= LOAD;
          end
        end
        LOAD: begin
          load_n_q <= 1'b1;
          state    <= RUN;
`ifdef DIV_ARB_TIMEOUT_EN
          run_cnt  <= '0;
`endif
        end
        RUN: begin
          if (div_done) begin
            resp_quotient  <= div_quotient;
            resp_remainder <= div_remainder;
            resp_error     <= div_error;
            resp_valid     <= NREQ'(1) << grant_idx;
            state          <= RESP;
          end
`ifdef DIV_ARB_TIMEOUT_EN
          // A hung divider is reported to the client as an error result.
          else if (run_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
            resp_quotient  <= '0;
            resp_remainder <= '0;
            resp_error     <= 1'b1;
            resp_valid     <= NREQ'(1) << grant_idx;
            state          <= RESP;
          end else begin
            run_cnt <= run_cnt + 1'b1;
          end
`endif
        end
        RESP: begin
          if (resp_ready[grant_idx]) begin
            resp_valid <= '0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_arbiter.sv
// Randomized self-checking bench for div_arbiter with a behavioural divider core.
module tb_div_arbiter;

  localparam int N    = 4;
  localparam int NREQ = 2;

  logic              clk;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*N-1:0] req_dividend;
  logic [NREQ*N-1:0] req_divisor;
  logic [NREQ-1:0]   resp_valid;
  logic [NREQ-1:0]   resp_ready;
  logic [N-1:0]      resp_quotient;
  logic [N-1:0]      resp_remainder;
  logic              resp_error;
  logic              div_load_n;
  logic [N-1:0]      div_dividend;
  logic [N-1:0]      div_divisor;
  logic [N-1:0]      div_quotient;
  logic [N-1:0]      div_remainder;
  logic              div_done;
  logic              div_error;

  int checks   = 0;
  int failures = 0;

  // Reference model: who is waiting, with what operands, and who was served last.
  bit         pendV[NREQ];
  logic [3:0] pendA[NREQ];
  logic [3:0] pendB[NREQ];
  int         lastGrant;

  div_arbiter #(
    .N    (N),
    .NREQ (NREQ)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_dividend   (req_dividend),
    .req_divisor    (req_divisor),
    .resp_valid     (resp_valid),
    .resp_ready     (resp_ready),
    .resp_quotient  (resp_quotient),
    .resp_remainder (resp_remainder),
    .resp_error     (resp_error),
    .div_load_n     (div_load_n),
    .div_dividend   (div_dividend),
    .div_divisor    (div_divisor),
    .div_quotient   (div_quotient),
    .div_remainder  (div_remainder),
    .div_done       (div_done),
    .div_error      (div_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Repeated-subtraction divider: loads while load_n is low, one subtract per cycle.
  logic [N-1:0] dvsr;
  logic         busy;
  always @(posedge clk) begin
    if (!div_load_n) begin
      div_quotient  <= '0;
      div_remainder <= div_dividend;
      dvsr          <= div_divisor;
      div_done      <= 1'b0;
      div_error     <= 1'b0;
      busy          <= 1'b1;
    end else if (busy) begin
      if (dvsr == 0) begin
        div_quotient  <= '0;
        div_remainder <= '0;
        div_error     <= 1'b1;
        div_done      <= 1'b1;
        busy          <= 1'b0;
      end else if (div_remainder >= dvsr) begin
        div_remainder <= div_remainder - dvsr;
        div_quotient  <= div_quotient + 1'b1;
      end else begin
        div_done <= 1'b1;
        busy     <= 1'b0;
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input int i, input logic [3:0] a, input logic [3:0] b);
    if (!pendV[i]) begin
      pendV[i]                = 1'b1;
      pendA[i]                = a;
      pendB[i]                = b;
      req_dividend[i*N +: N]  = a;
      req_divisor[i*N +: N]   = b;
      req_valid[i]            = 1'b1;
    end
  endtask

  function automatic int expGrant();
    for (int k = 1; k <= NREQ; k++) begin
      int c;
      c = (lastGrant + k) % NREQ;
      if (pendV[c]) return c;
    end
    return -1;
  endfunction

  task automatic doReset();
    rst        = 1'b1;
    req_valid  = '0;
    resp_ready = '0;
    for (int i = 0; i < NREQ; i++) pendV[i] = 1'b0;
    @(posedge clk); #1;
    checkOutput("rst_load_n", 32'(div_load_n), 0);
    checkOutput("rst_req_ready", 32'(req_ready), 0);
    rst = 1'b0;
    lastGrant = NREQ - 1;
    #1;
    checkOutput("rst_resp", {resp_valid, resp_quotient, resp_remainder, resp_error}, 0);
    checkOutput("rst_div_ops", {div_dividend, div_divisor}, 0);
    checkOutput("rst_released_load_n", 32'(div_load_n), 1);
  endtask

  // Serves the arbitration winner the model predicts, holding resp_ready low respDelay cycles.
  task automatic serveOne(input int respDelay);
    int         g, lat, n;
    logic [3:0] a, b, eq, er;
    logic       ee;
    #1;
    g = expGrant();
    if (g < 0) begin
      checkOutput("model_has_request", 0, 1);
      return;
    end
    checkOutput("req_ready_grant", 32'(req_ready), 32'(1 << g));
    a = pendA[g];
    b = pendB[g];
    if (b == 0) begin
      eq = 0; er = 0; ee = 1'b1; lat = 3;
    end else begin
      eq = a / b; er = a % b; ee = 1'b0; lat = int'(a / b) + 3;
    end
    @(posedge clk); #1;
    pendV[g]     = 1'b0;
    req_valid[g] = 1'b0;
    lastGrant    = g;
    checkOutput("load_n_low", 32'(div_load_n), 0);
    checkOutput("req_ready_load", 32'(req_ready), 0);
    @(posedge clk); #1;
    n = 1;
    checkOutput("div_operands", {div_dividend, div_divisor}, {a, b});
    checkOutput("load_n_run", 32'(div_load_n), 1);
    while (resp_valid == '0 && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("latency", 32'(n), 32'(lat));
    checkOutput("resp_valid", 32'(resp_valid), 32'(1 << g));
    checkOutput("resp_data", {resp_quotient, resp_remainder, resp_error}, {eq, er, ee});
    for (int d = 0; d < respDelay; d++) begin
      resp_ready = NREQ'($urandom) & ~(NREQ'(1) << g);
      @(posedge clk); #1;
      checkOutput("resp_hold", {resp_valid, resp_quotient, resp_remainder, resp_error},
                  {2'(1 << g), eq, er, ee});
      checkOutput("req_ready_resp", 32'(req_ready), 0);
    end
    resp_ready    = '0;
    resp_ready[g] = 1'b1;
    @(posedge clk); #1;
    resp_ready = '0;
    checkOutput("resp_valid_drop", 32'(resp_valid), 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst          = 1'b1;
    req_valid    = '0;
    resp_ready   = '0;
    req_dividend = '0;
    req_divisor  = '0;
    lastGrant    = NREQ - 1;
    doReset();

    // Single requester: 13/3.
    applyStimulus(0, 4'd13, 4'd3);
    serveOne(0);

    // Simultaneous requests straight after reset: requester 0 wins first.
    doReset();
    applyStimulus(0, 4'd7, 4'd9);
    applyStimulus(1, 4'd15, 4'd5);
    serveOne(0);
    serveOne(1);

    // Both continuously valid: grants must alternate.
    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < NREQ; i++) applyStimulus(i, 4'($urandom), 4'($urandom_range(1, 15)));
      serveOne($urandom_range(0, 2));
    end

    // Divide by zero from requester 1.
    applyStimulus(1, 4'd9, 4'd0);
    serveOne(0);

    // Slow response consumer while another requester waits.
    applyStimulus(0, 4'd14, 4'd2);
    applyStimulus(1, 4'd11, 4'd4);
    serveOne(5);
    serveOne(0);

    // Request withdrawn before an accept edge: no grant, no load.
    req_dividend[N +: N] = 4'd5;
    req_divisor[N +: N]  = 4'd1;
    req_valid[1]         = 1'b1;
    #1;
    checkOutput("drop_ready", 32'(req_ready), 32'(2));
    req_valid[1] = 1'b0;
    @(posedge clk); #1;
    checkOutput("drop_no_grant", {req_ready, div_load_n}, 1);

    // Reset in the middle of RUN abandons the operation.
    applyStimulus(0, 4'd15, 4'd1);
    #1;
    checkOutput("midrst_grant", 32'(req_ready), 32'(1));
    @(posedge clk); #1;
    pendV[0]  = 1'b0;
    req_valid = '0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    #1;
    checkOutput("midrst_load_n", 32'(div_load_n), 0);
    @(posedge clk); #1;
    checkOutput("midrst_resp", {resp_valid, resp_quotient, resp_remainder, resp_error}, 0);
    checkOutput("midrst_ops", {div_dividend, div_divisor, req_ready}, 0);
    rst       = 1'b0;
    lastGrant = NREQ - 1;
    begin
      int seen;
      seen = 0;
      repeat (20) begin
        @(posedge clk); #1;
        if (resp_valid != '0) seen++;
      end
      checkOutput("midrst_no_resp", 32'(seen), 0);
    end
    applyStimulus(0, 4'd6, 4'd2);
    serveOne(0);

    // Randomized traffic against the model.
    repeat (40) begin
      for (int i = 0; i < NREQ; i++) begin
        if ($urandom_range(0, 2) != 0)
          applyStimulus(i, 4'($urandom), ($urandom_range(0, 7) == 0) ? 4'd0 : 4'($urandom));
      end
      if (!pendV[0] && !pendV[1])
        applyStimulus(int'($urandom_range(0, 1)), 4'($urandom), 4'($urandom_range(1, 15)));
      serveOne(int'($urandom_range(0, 3)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
